// File: rtl/spi_slave_shift_reg_if.sv
// Pin-side and register-side signals of the SPI slave shift register.
// The slave modport is the shift register; the master modport is whoever
// drives the SPI pins and the register-side controls (slave regs or a bench).
interface spi_slave_shift_reg_if #(
  parameter int SPI_MAX_CHAR      = 32,
  parameter int SPI_CHAR_LEN_BITS = 5
);
  logic                         sclk;
  logic                         ss_n;
  logic                         mosi;
  logic                         miso;
  logic                         miso_oe;
  logic                         cpol;
  logic                         cpha;
  logic                         lsb;
  logic [SPI_CHAR_LEN_BITS-1:0] len;
  logic [SPI_MAX_CHAR-1:0]      tx_data;
  logic                         tx_load;
  logic                         tx_empty;
  logic [SPI_MAX_CHAR-1:0]      rx_data;
  logic                         rx_valid;
  logic                         rx_ack;
  logic                         rx_overrun;
  logic                         tx_underrun;
  logic                         frame_err;
  logic                         tip;

  modport slave (
    input  sclk, ss_n, mosi, cpol, cpha, lsb, len, tx_data, tx_load, rx_ack,
    output miso, miso_oe, tx_empty, rx_data, rx_valid, rx_overrun,
           tx_underrun, frame_err, tip
  );

  modport master (
    output sclk, ss_n, mosi, cpol, cpha, lsb, len, tx_data, tx_load, rx_ack,
    input  miso, miso_oe, tx_empty, rx_data, rx_valid, rx_overrun,
           tx_underrun, frame_err, tip
  );
endinterface

// File: rtl/spi_slave_shift_reg.sv
// SPI slave serializer/deserializer. Oversamples sclk/ss_n/mosi in the
// wb_clk_in domain, collects received bits into a character and serves miso
// from a one-deep transmit buffer. Pin-to-action latency is 3 clocks.
module spi_slave_shift_reg #(
  parameter int SPI_MAX_CHAR      = 32,
  parameter int SPI_CHAR_LEN_BITS = 5
) (
  input  logic                 wb_clk_in,
  input  logic                 wb_rst,
  spi_slave_shift_reg_if.slave bus
);

  localparam int CW = SPI_CHAR_LEN_BITS + 1;  // counter wide enough to hold N

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                       state;
  logic                         sclk_s1, sclk_s2, sclk_s3;
  logic                         ss_s1, ss_s2, ss_s3;
  logic                         mosi_s1, mosi_s2;
  logic                         rst_d, armed;
  logic [SPI_MAX_CHAR-1:0]      tx_buf, tx_sh, rx_sh, rx_next, rx_data_q, ld_char;
  logic [CW-1:0]                k, n_r, n_live, k_inc, k_eff;
  logic                         lsb_r, cpol_r, cpha_r;
  logic                         miso_q, oe_q, tip_q, tx_empty_q, rx_valid_q;
  logic                         ovr_q, und_q, fe_q;
  logic [SPI_CHAR_LEN_BITS-1:0] cur_idx, start_idx;
  logic                         sclk_chg, lead, trail, samp, shft;
  logic                         ss_fall, ss_rise, active, complete, do_start;

  // Position of bit k within an n-bit character for the chosen bit order.
  function automatic logic [SPI_CHAR_LEN_BITS-1:0] bit_idx(
    input logic [CW-1:0] kk, input logic [CW-1:0] n, input logic l);
    logic [CW-1:0] r;
    r = l ? kk : (n - kk - CW'(1));
    return SPI_CHAR_LEN_BITS'(r);
  endfunction

  // Two-flop synchronizers plus a history flop for sclk/ss_n edge detection.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      sclk_s1 <= bus.cpol; sclk_s2 <= bus.cpol; sclk_s3 <= bus.cpol;
      ss_s1   <= 1'b1;     ss_s2   <= 1'b1;     ss_s3   <= 1'b1;
      mosi_s1 <= 1'b0;     mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= bus.sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
      ss_s1   <= bus.ss_n; ss_s2   <= ss_s1;   ss_s3   <= ss_s2;
      mosi_s1 <= bus.mosi; mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_chg  = sclk_s2 ^ sclk_s3;
  assign lead      = sclk_chg && (sclk_s2 != cpol_r);
  assign trail     = sclk_chg && (sclk_s2 == cpol_r);
  assign samp      = cpha_r ? trail : lead;
  assign shft      = cpha_r ? lead  : trail;
  assign ss_fall   = ss_s3 & ~ss_s2;
  assign ss_rise   = ~ss_s3 & ss_s2;
  assign active    = (state == ACTIVE);

  assign n_live    = (bus.len == '0) ? CW'(SPI_MAX_CHAR) : {1'b0, bus.len};
  assign ld_char   = tx_empty_q ? '0 : tx_buf;
  assign start_idx = bit_idx('0, n_live, bus.lsb);
  assign cur_idx   = bit_idx(k, n_r, lsb_r);
  assign k_inc     = k + CW'(1);
  assign k_eff     = samp ? k_inc : k;
  assign complete  = active && samp && (k_inc == n_r);
  assign do_start  = (!active && ss_fall && armed) || (complete && !ss_rise);

  // Received character with the current sample merged in.
  always_comb begin
    rx_next          = rx_sh;
    rx_next[cur_idx] = mosi_s2;
  end

  // Transfer FSM, character assembly, transmit buffer and status pulses.
  // rst_d/armed keep a post-reset ss_n that is already low from looking
  // like a fresh falling edge: a start needs ss_n seen high after reset.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      state      <= IDLE;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      tip_q      <= 1'b0;
      tx_empty_q <= 1'b1;
      tx_buf     <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      fe_q       <= 1'b0;
      k          <= '0;
      n_r        <= '0;
      lsb_r      <= 1'b0;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      rst_d      <= 1'b1;
      armed      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      und_q <= 1'b0;
      fe_q  <= 1'b0;
      rst_d <= 1'b0;
      if (!rst_d && ss_s1) armed <= 1'b1;
      if (bus.rx_ack) rx_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          oe_q   <= 1'b0;
          tip_q  <= 1'b0;
          if (ss_fall && armed) begin
            state <= ACTIVE;
            oe_q  <= 1'b1;
            tip_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (samp) begin
            k     <= k_inc;
            rx_sh <= rx_next;
            if (k_inc == n_r) begin
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              ovr_q      <= rx_valid_q & ~bus.rx_ack;
            end
          end else if (shft && (cpha_r || k != n_r)) begin
            miso_q <= tx_sh[cur_idx];
          end
          if (ss_rise) begin
            state  <= IDLE;
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
            tip_q  <= 1'b0;
            k      <= '0;
            if (!complete && k_eff != '0) fe_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Char start: consume the buffer and latch the mode for this character.
      if (do_start) begin
        tx_sh      <= ld_char;
        und_q      <= tx_empty_q;
        tx_empty_q <= 1'b1;
        k          <= '0;
        rx_sh      <= '0;
        n_r        <= n_live;
        lsb_r      <= bus.lsb;
        cpol_r     <= bus.cpol;
        cpha_r     <= bus.cpha;
        if (!bus.cpha) miso_q <= ld_char[start_idx];
      end

      // A load in the start cycle lands after the buffer was consumed.
      if (bus.tx_load) begin
        tx_buf     <= bus.tx_data;
        tx_empty_q <= 1'b0;
      end
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = oe_q;
  assign bus.tip         = tip_q;
  assign bus.tx_empty    = tx_empty_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.tx_underrun = und_q;
  assign bus.frame_err   = fe_q;

endmodule

// File: tb/tb_spi_slave_shift_reg.sv
// Directed bench for spi_slave_shift_reg: bit-bangs an SPI master, queues
// expected rx/tx characters and compares them when each character finishes.
module tb_spi_slave_shift_reg;

  localparam int H = 6;  // sclk half-period in wb_clk_in cycles

  logic wb_clk_in = 1'b0;
  logic wb_rst;
  always #5 wb_clk_in = ~wb_clk_in;

  spi_slave_shift_reg_if #(.SPI_MAX_CHAR(32), .SPI_CHAR_LEN_BITS(5)) bus ();

  spi_slave_shift_reg #(.SPI_MAX_CHAR(32), .SPI_CHAR_LEN_BITS(5)) dut (
    .wb_clk_in (wb_clk_in),
    .wb_rst    (wb_rst),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int ovr_cnt = 0, und_cnt = 0, fe_cnt = 0;
  logic [31:0] exp_rx_q[$];
  logic [31:0] exp_tx_q[$];

  // Count single-cycle status pulses, sampled just after each rising edge.
  always @(posedge wb_clk_in) begin
    #2;
    if (bus.rx_overrun)  ovr_cnt++;
    if (bus.tx_underrun) und_cnt++;
    if (bus.frame_err)   fe_cnt++;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge wb_clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    wclk(1);
    bus.tx_load = 1'b0;
  endtask

  // Wait out half a bit after a sample edge, optionally pulsing rx_ack
  // exactly in the cycle the slave acts on that edge.
  task automatic half_after_sample(input logic ack);
    if (ack) begin
      wclk(2); bus.rx_ack = 1'b1; wclk(1); bus.rx_ack = 1'b0; wclk(H - 3);
    end else begin
      wclk(H);
    end
  endtask

  // Master side of nb bits; cap collects miso at each master sample point.
  task automatic xfer(input int nb, input logic [31:0] w, input logic ack_last,
                      output logic [31:0] cap);
    int n;
    n = (bus.len == 5'd0) ? 32 : int'(bus.len);
    cap = '0;
    for (int k = 0; k < nb; k++) begin
      int ix;
      ix = bus.lsb ? k : n - 1 - k;
      if (!bus.cpha) begin
        bus.mosi = w[ix];
        wclk(H);
        bus.sclk = ~bus.cpol;
        cap[ix] = bus.miso;
        half_after_sample(ack_last && k == nb - 1);
        bus.sclk = bus.cpol;
      end else begin
        wclk(H);
        bus.sclk = ~bus.cpol;
        bus.mosi = w[ix];
        wclk(H);
        bus.sclk = bus.cpol;
        cap[ix] = bus.miso;
        half_after_sample(ack_last && k == nb - 1);
        wclk(0);
      end
    end
    wclk(H);
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1;
    wclk(1);
    bus.rx_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] cap;
    int s_ovr, s_und, s_fe;

    wb_rst = 1'b1;
    bus.sclk = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb = 1'b0; bus.len = 5'd8;
    bus.tx_data = '0; bus.tx_load = 1'b0; bus.rx_ack = 1'b0;
    wclk(3);
    chk("rst_flags", 32'({bus.miso, bus.miso_oe, bus.tx_empty, bus.rx_valid, bus.tip,
                          bus.rx_overrun, bus.tx_underrun, bus.frame_err}), 32'b0010_0000);
    chk("rst_rx_data", bus.rx_data, 32'h0);
    wb_rst = 1'b0;
    wclk(4);

    // Mode 0, MSB first, 8 bits.
    load(32'hA5); exp_tx_q.push_back(32'hA5);
    chk("t1_tx_empty_loaded", 32'(bus.tx_empty), 32'd0);
    s_fe = fe_cnt;
    bus.ss_n = 1'b0;
    wclk(H);
    chk("t1_active_first_bit", 32'({bus.tip, bus.miso_oe, bus.miso}), 32'b111);
    exp_rx_q.push_back(32'h3C);
    xfer(8, 32'h3C, 1'b0, cap);
    chk("t1_miso_word", cap, exp_tx_q.pop_front());
    chk("t1_rx_data", bus.rx_data, exp_rx_q.pop_front());
    chk("t1_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("t1_tx_empty", 32'(bus.tx_empty), 32'd1);
    bus.ss_n = 1'b1;
    wclk(H);
    chk("t1_idle", 32'({bus.tip, bus.miso_oe, bus.miso}), 32'b000);
    chk("t1_no_frame_err", 32'(fe_cnt - s_fe), 32'd0);
    ack();
    chk("t1_ack_clears", 32'(bus.rx_valid), 32'd0);

    // Mode 3, LSB first, 32 bits.
    bus.cpol = 1'b1; bus.cpha = 1'b1; bus.lsb = 1'b1; bus.len = 5'd0; bus.sclk = 1'b1;
    wclk(H);
    load(32'hDEADBEEF); exp_tx_q.push_back(32'hDEADBEEF);
    bus.ss_n = 1'b0;
    wclk(H);
    exp_rx_q.push_back(32'h12345678);
    xfer(32, 32'h12345678, 1'b0, cap);
    chk("t2_miso_word", cap, exp_tx_q.pop_front());
    chk("t2_rx_data", bus.rx_data, exp_rx_q.pop_front());
    bus.ss_n = 1'b1;
    wclk(H);
    ack();

    // Back-to-back chars, no ack: overrun on the second, underrun on its start.
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb = 1'b0; bus.len = 5'd8; bus.sclk = 1'b0;
    wclk(H);
    load(32'h81); exp_tx_q.push_back(32'h81); exp_tx_q.push_back(32'h00);
    s_ovr = ovr_cnt; s_und = und_cnt;
    bus.ss_n = 1'b0;
    wclk(H);
    exp_rx_q.push_back(32'h01);
    xfer(8, 32'h01, 1'b0, cap);
    chk("t3_c1_miso_word", cap, exp_tx_q.pop_front());
    chk("t3_c1_rx_data", bus.rx_data, exp_rx_q.pop_front());
    chk("t3_c2_underrun", 32'(und_cnt - s_und), 32'd1);
    exp_rx_q.push_back(32'h02);
    xfer(8, 32'h02, 1'b0, cap);
    chk("t3_c2_miso_zero", cap, exp_tx_q.pop_front());
    chk("t3_c2_rx_data", bus.rx_data, exp_rx_q.pop_front());
    chk("t3_overrun_once", 32'(ovr_cnt - s_ovr), 32'd1);
    bus.ss_n = 1'b1;
    wclk(H);
    ack();

    // ss_n rises after 5 of 8 bits.
    load(32'h5A);
    s_fe = fe_cnt;
    bus.ss_n = 1'b0;
    wclk(H);
    xfer(5, 32'h1F, 1'b0, cap);
    bus.ss_n = 1'b1;
    wclk(2);
    chk("t4_oe_still_on", 32'(bus.miso_oe), 32'd1);
    wclk(1);
    chk("t4_oe_off", 32'(bus.miso_oe), 32'd0);
    chk("t4_frame_err", 32'(fe_cnt - s_fe), 32'd1);
    chk("t4_no_rx_valid", 32'(bus.rx_valid), 32'd0);
    wclk(H);

    // tx_load in the start cycle, then rx_ack coinciding with a completion.
    s_ovr = ovr_cnt;
    bus.ss_n = 1'b0;
    wclk(2);
    bus.tx_data = 32'h77; bus.tx_load = 1'b1;
    wclk(1);
    bus.tx_load = 1'b0;
    chk("t5_tx_empty_after_start", 32'(bus.tx_empty), 32'd0);
    exp_tx_q.push_back(32'h00); exp_tx_q.push_back(32'h77);
    wclk(H);
    exp_rx_q.push_back(32'h11);
    xfer(8, 32'h11, 1'b0, cap);
    chk("t5_c1_miso_zero", cap, exp_tx_q.pop_front());
    chk("t5_c1_rx_data", bus.rx_data, exp_rx_q.pop_front());
    exp_rx_q.push_back(32'h22);
    xfer(8, 32'h22, 1'b1, cap);
    chk("t5_c2_miso_word", cap, exp_tx_q.pop_front());
    chk("t5_c2_rx_data", bus.rx_data, exp_rx_q.pop_front());
    chk("t5_c2_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("t5_no_overrun", 32'(ovr_cnt - s_ovr), 32'd0);
    bus.ss_n = 1'b1;
    wclk(H);
    ack();

    // Reset mid-character; a fresh ss_n falling edge is needed afterwards.
    load(32'hF0);
    bus.ss_n = 1'b0;
    wclk(H);
    xfer(3, 32'hFF, 1'b0, cap);
    wb_rst = 1'b1;
    wclk(1);
    wb_rst = 1'b0;
    chk("t6_rst_flags", 32'({bus.miso, bus.miso_oe, bus.tx_empty, bus.rx_valid, bus.tip}),
        32'b00100);
    chk("t6_rst_rx_data", bus.rx_data, 32'h0);
    xfer(8, 32'h55, 1'b0, cap);
    chk("t6_ignored_without_fresh_ss", 32'({bus.rx_valid, bus.tip, bus.miso_oe}), 32'b000);
    bus.ss_n = 1'b1;
    wclk(H);
    load(32'h3C); exp_tx_q.push_back(32'h3C);
    bus.ss_n = 1'b0;
    wclk(H);
    exp_rx_q.push_back(32'h99);
    xfer(8, 32'h99, 1'b0, cap);
    chk("t6_miso_word", cap, exp_tx_q.pop_front());
    chk("t6_rx_data", bus.rx_data, exp_rx_q.pop_front());
    chk("t6_rx_valid", 32'(bus.rx_valid), 32'd1);
    bus.ss_n = 1'b1;
    wclk(H);
    chk("sb_drained", 32'(exp_rx_q.size() + exp_tx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
